// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/halfword/word load-store front end for word-only DataMemory
//
// Purpose: converts lb/lbu/lh/lhu/lw/sb/sh/sw into word accesses on a DataMemory
// with synchronous read. Sub-word stores use read-modify-write. Loads are lane
// extracted and sign/zero extended. busy_o stalls the pipeline while an access is in flight.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned halfword/word and size 11 complete at once with misaligned_o = 1
//   undefined - low address bits are forced to alignment, size 11 acts as word, misaligned_o = 0
//
// Ports:
//   clk_i, rst_i          clock; asynchronous active-high reset
//   req_i                 access request, sampled only in IDLE
//   we_i                  1 = store, 0 = load
//   size_i                00 byte, 01 halfword, 10 word, 11 reserved
//   sign_ext_i            loads: 1 sign-extend, 0 zero-extend
//   byte_addr_i           byte address
//   wdata_i               right-aligned store data
//   rdata_o               last load result, aligned and extended
//   done_o                one-cycle completion pulse
//   busy_o                high whenever the FSM is not in IDLE
//   misaligned_o          fault flag, qualified by done_o
//   mem_wr_rd_o           DataMemory wr_rd (1 read, 0 write)
//   mem_addr_o            DataMemory word address
//   mem_data_out_o        DataMemory data_in
//   mem_data_in_i         DataMemory data_out
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  sign_ext_i,
    input  logic [ADDR_WIDTH+1:0] byte_addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  misaligned_o,
    output logic                  mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_out_o,
    input  logic [DATA_WIDTH-1:0] mem_data_in_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [1:0]              size_q, size_d;
    logic                    sext_q, sext_d;
    logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
    logic [15:0]             wdata_q, wdata_d;
    logic                    fault_q, fault_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   mdo_q, mdo_d;

    // Request qualification: effective size/address and fault decision
    logic                    fault_c;
    logic [1:0]              size_c;
    logic [ADDR_WIDTH+1:0]   addr_c;

    always_comb begin
        size_c  = size_i;
        addr_c  = byte_addr_i;
        fault_c = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (size_i)
            2'b00:   fault_c = 1'b0;
            2'b01:   fault_c = byte_addr_i[0];
            2'b10:   fault_c = |byte_addr_i[1:0];
            default: fault_c = 1'b1;
        endcase
`else
        if (size_i == 2'b11) begin
            size_c = 2'b10;
        end
        if (size_c == 2'b01) begin
            addr_c[0] = 1'b0;
        end
        if (size_c == 2'b10) begin
            addr_c[1:0] = 2'b00;
        end
`endif
    end

    // Lane extraction and store merge, both working on the word returned by the read
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        byte_sel = mem_data_in_i[{addr_q[1:0], 3'b000} +: 8];
        half_sel = mem_data_in_i[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = {{(DATA_WIDTH-8){sext_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{(DATA_WIDTH-16){sext_q & half_sel[15]}}, half_sel};
            default: load_val = mem_data_in_i;
        endcase
        merged = mem_data_in_i;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
            default: merged = mem_data_in_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        mdo_d   = mdo_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_c;
                    sext_d  = sign_ext_i;
                    addr_d  = addr_c;
                    wdata_d = wdata_i[15:0];
                    fault_d = fault_c;
                    if (fault_c) begin
                        state_d = S_DONE;
                    end else if (we_i && (size_c == 2'b10)) begin
                        // Full-word store needs no read; data is ready for WR.
                        mdo_d   = wdata_i;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:   state_d = S_CAP;
            S_CAP: begin
                if (we_q) begin
                    mdo_d   = merged;
                    state_d = S_WR;
                end else begin
                    rdata_d = load_val;
                    state_d = S_DONE;
                end
            end
            S_WR:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            mdo_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            mdo_q   <= mdo_d;
        end
    end

    // Outputs decode straight from state so reset drops a pending write immediately.
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign mem_wr_rd_o    = (state_q != S_WR);
    assign misaligned_o   = done_o & fault_q;
    assign rdata_o        = rdata_q;
    assign mem_addr_o     = addr_q[ADDR_WIDTH+1:2];
    assign mem_data_out_o = mdo_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [11:0] byte_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        misaligned;
    logic        mem_wr_rd;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .we_i           (we),
        .size_i         (size),
        .sign_ext_i     (sign_ext),
        .byte_addr_i    (byte_addr),
        .wdata_i        (wdata),
        .rdata_o        (rdata),
        .done_o         (done),
        .busy_o         (busy),
        .misaligned_o   (misaligned),
        .mem_wr_rd_o    (mem_wr_rd),
        .mem_addr_o     (mem_addr),
        .mem_data_out_o (mem_data_out),
        .mem_data_in_i  (mem_data_in)
    );

    // DataMemory stand-in: write on edge when wr_rd = 0, registered read
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (!mem_wr_rd) mem[mem_addr] <= mem_data_out;
        mem_data_in <= mem[mem_addr];
    end

    int checks = 0;
    int passes = 0;

    logic [31:0] ref_mem [0:1023];
    logic [31:0] last_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          nwr;
        logic [31:0] wr_data;
        logic [9:0]  wr_addr;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_val;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sx, input logic [1:0] off);
        logic [31:0] sh;
        sh = w >> (off * 8);
        case (sz)
            2'd0:    return sx ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
            2'd1:    return sx ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] mask;
        case (sz)
            2'd0:    mask = 32'h0000_00FF << (off * 8);
            2'd1:    mask = 32'h0000_FFFF << (off * 8);
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (w & ~mask) | ((wd << (off * 8)) & mask);
    endfunction

    // Issue one access, model its outcome into the scoreboard, then check what the DUT did.
    task automatic run(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [11:0] a, input logic [31:0] wd,
                       output logic [31:0] got_rdata, output logic [31:0] got_wr);
        exp_t        e;
        exp_t        p;
        logic        flt;
        logic [1:0]  esz;
        logic [11:0] ea;
        int          lat;
        int          nwr;
        int          nbusy;
        logic        mis;
        logic [9:0]  wa;
        bit          got;
`ifdef LSU_MISALIGN_TRAP_EN
        flt = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        esz = sz;
        ea  = a;
`else
        flt = 1'b0;
        esz = (sz == 2'd3) ? 2'd2 : sz;
        ea  = a;
        if (esz == 2'd1) ea[0] = 1'b0;
        if (esz == 2'd2) ea[1:0] = 2'b00;
`endif
        e.wr_addr = ea[11:2];
        e.wr_data = 32'h0;
        e.mis     = flt;
        if (flt) begin
            e.lat = 1; e.nwr = 0; e.rdata = last_rdata;
        end else if (!w) begin
            last_rdata = m_load(ref_mem[ea[11:2]], esz, sx, ea[1:0]);
            e.lat = 3; e.nwr = 0; e.rdata = last_rdata;
        end else begin
            e.wr_data = m_store(ref_mem[ea[11:2]], esz, ea[1:0], wd);
            ref_mem[ea[11:2]] = e.wr_data;
            e.lat = (esz == 2'd2) ? 2 : 4;
            e.nwr = 1; e.rdata = last_rdata;
        end
        sbq.push_back(e);

        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign_ext = sx; byte_addr = a; wdata = wd;
        @(negedge clk);
        req = 1'b0;
        lat = 0; nwr = 0; nbusy = 0; got = 1'b0; mis = 1'b0;
        got_rdata = 32'h0; got_wr = 32'h0; wa = 10'h0;
        for (int c = 1; c <= 10; c++) begin
            if (busy) nbusy++;
            if (!mem_wr_rd) begin nwr++; got_wr = mem_data_out; wa = mem_addr; end
            if (done) begin
                lat = c; mis = misaligned; got_rdata = rdata; got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        p = sbq.pop_front();
        chk("done_seen", {31'h0, got}, 32'h1);
        chk("latency", lat, p.lat);
        chk("busy_cycles", nbusy, p.lat);
        chk("misaligned", {31'h0, mis}, {31'h0, p.mis});
        chk("rdata", got_rdata, p.rdata);
        chk("write_count", nwr, p.nwr);
        if (p.nwr != 0) begin
            chk("write_data", got_wr, p.wr_data);
            chk("write_addr", {22'h0, wa}, {22'h0, p.wr_addr});
        end
    endtask

    vec_t        vecs[8];
    logic [31:0] r, wv;
    int          busy_seen;
    int          done_seen;
    int          nd;
    logic [7:0]  busy_pat;
    logic [7:0]  done_pat;

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        byte_addr = 12'h0; wdata = 32'h0; last_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
        chk("rst_mem_wr_rd", {31'h0, mem_wr_rd}, 32'h1);
        chk("rst_mem_addr", {22'h0, mem_addr}, 32'h0);
        chk("rst_mem_data_out", mem_data_out, 32'h0);
        rst = 1'b0;

        // Preload words 0..3 through the unit itself
        run(1'b1, 2'd2, 1'b0, 12'd0,  32'h1122_3344, r, wv);
        run(1'b1, 2'd2, 1'b0, 12'd4,  32'h80FF_7F01, r, wv);
        run(1'b1, 2'd2, 1'b0, 12'd8,  32'hDEAD_BEEF, r, wv);
        run(1'b1, 2'd2, 1'b0, 12'd12, 32'h0F0F_F0F0, r, wv);
        chk("preload_word1", mem[1], 32'h80FF_7F01);

        vecs[0] = '{1'b0, 2'd2, 1'b0, 12'd4, 32'h0,          32'h80FF_7F01};
        vecs[1] = '{1'b0, 2'd0, 1'b1, 12'd7, 32'h0,          32'hFFFF_FF80};
        vecs[2] = '{1'b0, 2'd0, 1'b0, 12'd7, 32'h0,          32'h0000_0080};
        vecs[3] = '{1'b0, 2'd0, 1'b1, 12'd5, 32'h0,          32'h0000_007F};
        vecs[4] = '{1'b0, 2'd1, 1'b1, 12'd6, 32'h0,          32'hFFFF_80FF};
        vecs[5] = '{1'b0, 2'd1, 1'b0, 12'd6, 32'h0,          32'h0000_80FF};
        vecs[6] = '{1'b1, 2'd0, 1'b0, 12'd6, 32'h0000_00AA,  32'h80AA_7F01};
        vecs[7] = '{1'b0, 2'd2, 1'b0, 12'd4, 32'h0,          32'h80AA_7F01};
        foreach (vecs[i]) begin
            run(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata, r, wv);
            if (vecs[i].we) chk($sformatf("vec%0d_wr", i), wv, vecs[i].exp_val);
            else            chk($sformatf("vec%0d_rd", i), r, vecs[i].exp_val);
        end

        // Misaligned word store: fault with trap, forced-aligned write without
        run(1'b1, 2'd2, 1'b0, 12'd5, 32'h1234_5678, r, wv);
        chk("sw5_word1", mem[1], ref_mem[1]);
        run(1'b0, 2'd1, 1'b1, 12'd7, 32'h0, r, wv);
        run(1'b0, 2'd3, 1'b0, 12'd8, 32'h0, r, wv);

        // Reset during the write cycle of a halfword store
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd1; sign_ext = 1'b0; byte_addr = 12'd4; wdata = 32'h0000_BEEF;
        @(negedge clk);
        req = 1'b0;
        for (int c = 0; c < 10 && mem_wr_rd; c++) @(negedge clk);
        chk("rstwr_reached_wr", {31'h0, mem_wr_rd}, 32'h0);
        rst = 1'b1;
        #1;
        chk("rstwr_mem_wr_rd", {31'h0, mem_wr_rd}, 32'h1);
        chk("rstwr_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("rstwr_word1", mem[1], ref_mem[1]);
        chk("rstwr_rdata", rdata, 32'h0);
        rst = 1'b0;
        last_rdata = 32'h0;
        nd = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("rstwr_no_done", nd, 0);

        // Continuous req during lw: accepts again only after DONE
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd2; sign_ext = 1'b0; byte_addr = 12'd4;
        busy_pat = 8'h0; done_pat = 8'h0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            busy_pat[7-c] = busy;
            done_pat[7-c] = done;
            if (c == 7) req = 1'b0;
        end
        last_rdata = ref_mem[1];
        chk("hold_busy_pattern", {24'h0, busy_pat}, 32'h0000_00EE);
        chk("hold_done_pattern", {24'h0, done_pat}, 32'h0000_0022);
        chk("hold_rdata", rdata, ref_mem[1]);

        // Random mix across words 0..3 against the model
        for (int i = 0; i < 24; i++) begin
            run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                12'($urandom_range(0, 15)), $urandom, r, wv);
        end
        for (int i = 0; i < 4; i++) chk($sformatf("final_word%0d", i), mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access front end for the MIPS datapath, sitting between the MEM pipeline stage and `DataMemory`. It turns byte, halfword and word loads/stores (lb/lbu/lh/lhu/lw/sb/sh/sw) into word-only `DataMemory` accesses. Sub-word stores use read-modify-write sequencing, and loads are lane-extracted and extended. While an access is in flight it stalls the pipeline through `busy`, and it flags misaligned accesses.

## Interface
- `DATA_WIDTH`, 32, data word width; only 32 is supported.
- `ADDR_WIDTH`, 10, `DataMemory` word-address width.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req`  in  1  access request, sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- `sign_ext`  in  1  loads only: 1 sign-extends, 0 zero-extends.
- `byte_addr`  in  ADDR_WIDTH+2  byte address.
- `wdata`  in  32  store data, right-aligned.
- `rdata`  out  32  load result, aligned and extended.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  pipeline stall.
- `misaligned`  out  1  fault flag, valid only with `done`.
- `mem_wr_rd`  out  1  to `DataMemory.wr_rd`: 1 = read, 0 = write.
- `mem_addr`  out  ADDR_WIDTH  word address, equal to `byte_addr[ADDR_WIDTH+1:2]`.
- `mem_data_out`  out  32  to `DataMemory.data_in`.
- `mem_data_in`  in  32  from `DataMemory.data_out`.

## Operation
- **DataMemory contract**
  - Writes occur on the rising edge when `wr_rd` is 0.
  - Reads are synchronous: data is valid the cycle after the address is presented.
- **Request capture.** On `req` in IDLE, the unit latches `we`, `size`, `sign_ext`, `byte_addr` and `wdata`. A `req` in any other state is ignored.
- **Byte lanes (little-endian)**
  - Byte offset k maps to bits `[8k+7:8k]`.
  - Halfword offset 0 maps to `[15:0]`; offset 2 maps to `[31:16]`.
- **Alignment**
  - A halfword requires `byte_addr[0]` = 0.
  - A word requires `byte_addr[1:0]` = 00.
  - `size` = 11 always faults.
- **FSM states:** IDLE, RD, CAP, WR, DONE.
  - IDLE goes to DONE on a fault.
  - IDLE goes to RD on a load or a sub-word store.
  - IDLE goes to WR on a word store.
  - RD goes to CAP.
  - CAP goes to DONE for a load.
  - CAP goes to WR for a store. CAP merges the store lane(s) into the captured word and registers the result into `mem_data_out`.
  - WR goes to DONE.
  - DONE goes to IDLE.
- **Memory drive**
  - `mem_wr_rd` is 0 only in WR, and 1 otherwise.
  - A word store drives `mem_data_out` with `wdata`.
- **Load result**
  - In CAP the selected lane is extended and registered into `rdata`.
  - `rdata` holds until the next load completes. Stores and faults leave it unchanged.
- **Fault completion.** `done` = 1 and `misaligned` = 1 in the same cycle. No memory write occurs.
- **busy** equals (state != IDLE). It is combinational from state.

## Timing
- Latency, from the acceptance edge to the `done` cycle:
  - load: 3 cycles;
  - sub-word store: 4 cycles;
  - word store: 2 cycles;
  - fault: 1 cycle.
- Throughput: the next request can be accepted in the cycle after DONE.
- Sub-word stores issue exactly one read and then exactly one write.
- Reset values:
  - state IDLE;
  - `rdata`, `mem_addr`, `mem_data_out` = 0;
  - `done`, `misaligned`, `busy` = 0;
  - `mem_wr_rd` = 1.
- **Reset mid-operation**
  - Asserting `rst` forces `mem_wr_rd` to 1 immediately, asynchronously.
  - A write pending in WR is not performed.
  - No `done` pulse is produced for the aborted access.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:** alignment checking and the fault path are active, as described above.
- **`LSU_MISALIGN_TRAP_EN` undefined**
  - Low address bits are forced to alignment: halfword clears bit 0, word clears bits 1:0.
  - The access proceeds normally.
  - `size` = 11 is treated as a word access.
  - `misaligned` is tied to 0.

## Test plan
- Preload word 1 with `32'h80FF7F01`, then issue lw at `byte_addr` = 4.
  - `busy` is high for 3 cycles.
  - `done` pulses with `rdata` = `32'h80FF7F01`.
  - `mem_wr_rd` never goes to 0.
- Sub-word loads from the same word:
  - lb at `byte_addr` = 7 gives `32'hFFFFFF80`.
  - lbu at `byte_addr` = 7 gives `32'h00000080`.
  - lb at `byte_addr` = 5 gives `32'h0000007F`.
  - lh at `byte_addr` = 6 gives `32'hFFFF80FF`.
  - lhu at `byte_addr` = 6 gives `32'h000080FF`.
- sb with `wdata` = `32'h000000AA` at `byte_addr` = 6:
  - one read, then a single write cycle with `mem_data_out` = `32'h80AA7F01`;
  - `done` arrives 4 cycles after acceptance;
  - a following lw at 4 returns `32'h80AA7F01`.
- sw at `byte_addr` = 5 (trap enabled):
  - `done` and `misaligned` pulse 1 cycle after acceptance;
  - `mem_wr_rd` stays 1;
  - word 1 is unchanged.
- sh at `byte_addr` = 4 with `rst` pulsed during WR:
  - `mem_wr_rd` returns to 1 within the same cycle;
  - word 1 is unchanged, state is IDLE, and no `done` pulse occurs.
- `req` asserted continuously during an lw:
  - only the first request is accepted;
  - a second access starts only after DONE, one cycle later.
